// File: rtl/transpose_pkg.sv
// transpose_pkg: shared bank-state type, index-width helper and legal range for the ping-pong transpose buffer
package transpose_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  function automatic int IDX_W(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/transpose_pingpong_if.sv
// transpose_pingpong_if: row-in / beat-out valid-ready bundle; i_bypass exists only with TRANSPOSE_BYPASS_EN
interface transpose_pingpong_if #(parameter int N = 8, parameter int DATA_W = 12);
  logic i_valid;
  logic o_ready;
  logic [N*DATA_W-1:0] i_data;
`ifdef TRANSPOSE_BYPASS_EN
  logic i_bypass;
`endif
  logic o_valid;
  logic i_ready;
  logic [N*DATA_W-1:0] o_data;
  logic o_last;
  modport master (output i_valid, i_data, i_ready,
`ifdef TRANSPOSE_BYPASS_EN
                  output i_bypass,
`endif
                  input o_ready, o_valid, o_data, o_last);
  modport slave (input i_valid, i_data, i_ready,
`ifdef TRANSPOSE_BYPASS_EN
                 input i_bypass,
`endif
                 output o_ready, o_valid, o_data, o_last);
endinterface

// File: rtl/transpose_bank.sv
// transpose_bank: one NxN register bank with a row write port, a column read port and a row read port
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_W = 12,
  parameter int IW = IDX_W(N)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IW-1:0]       wr_row,
  input  logic [N*DATA_W-1:0] wr_data,
  input  logic [IW-1:0]       rd_col,
  output logic [N*DATA_W-1:0] col_data,
  input  logic [IW-1:0]       rd_row,
  output logic [N*DATA_W-1:0] row_data
);
  logic [N*DATA_W-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[wr_row] <= wr_data;
  for (genvar j = 0; j < N; j++) begin : g_col
    assign col_data[j*DATA_W +: DATA_W] = mem[j][rd_col*DATA_W +: DATA_W];
  end
  assign row_data = mem[rd_row];
endmodule

// File: rtl/transpose_pingpong.sv
// transpose_pingpong: two-bank block transpose, rows in / columns out with valid-ready and o_last.
// Define TRANSPOSE_BYPASS_EN to add a per-block pass-through mode selected by i_bypass on row 0.
module transpose_pingpong
  import transpose_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_W = 12
) (
  input logic i_clk,
  input logic i_rst,
  transpose_pingpong_if.slave bus
);
  localparam int IW = IDX_W(N);
  localparam int W = N * DATA_W;
  bank_state_t st [2];
  bank_state_t st_nx [2];
  logic wr_sel, rd_sel;
  logic [IW-1:0] wr_row, rd_col;
  logic [W-1:0] col_d [2];
  logic [W-1:0] row_d [2];
  logic [1:0] wr_hit, rd_hit;
  logic acc, con, row_last, col_last, byp_rd;
  assign bus.o_ready = st[wr_sel] == EMPTY || st[wr_sel] == FILLING;
  assign bus.o_valid = st[rd_sel] == FULL || st[rd_sel] == DRAINING;
  assign acc = bus.i_valid && bus.o_ready;
  assign con = bus.o_valid && bus.i_ready;
  assign row_last = wr_row == IW'(N - 1);
  assign col_last = rd_col == IW'(N - 1);
  assign wr_hit = {acc && wr_sel, acc && !wr_sel};
  assign rd_hit = {con && rd_sel, con && !rd_sel};
  assign bus.o_last = bus.o_valid && col_last;
  // forced to zero when idle so the reset value of o_data is defined despite unreset banks
  assign bus.o_data = bus.o_valid ? (byp_rd ? row_d[rd_sel] : col_d[rd_sel]) : '0;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(.N(N), .DATA_W(DATA_W)) u_bank (
      .clk(i_clk), .we(wr_hit[b]), .wr_row(wr_row), .wr_data(bus.i_data),
      .rd_col(rd_col), .col_data(col_d[b]), .rd_row(rd_col), .row_data(row_d[b])
    );
  end
  always_comb
    for (int i = 0; i < 2; i++)
      st_nx[i] = (st[i] == EMPTY && wr_hit[i]) ? FILLING :
                 (st[i] == FILLING && wr_hit[i] && row_last) ? FULL :
                 (st[i] == FULL && rd_hit[i]) ? DRAINING :
                 (st[i] == DRAINING && rd_hit[i] && col_last) ? EMPTY : st[i];
  always_ff @(posedge i_clk)
    if (i_rst) begin
      st <= '{EMPTY, EMPTY};
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      st <= st_nx;
      if (acc) begin
        wr_row <= row_last ? '0 : wr_row + 1'b1;
        wr_sel <= wr_sel ^ row_last;
      end
      if (con) begin
        rd_col <= col_last ? '0 : rd_col + 1'b1;
        rd_sel <= rd_sel ^ col_last;
      end
    end
`ifdef TRANSPOSE_BYPASS_EN
  logic [1:0] byp;
  assign byp_rd = byp[rd_sel];
  always_ff @(posedge i_clk)
    if (i_rst) byp <= '0;
    else if (acc && wr_row == '0) byp[wr_sel] <= bus.i_bypass;
`else
  assign byp_rd = 1'b0;
`endif
endmodule

// File: tb/tb_transpose_pingpong.sv
// tb_transpose_pingpong: scoreboard bench for transpose_pingpong; covers bypass when TRANSPOSE_BYPASS_EN is defined
module tb_transpose_pingpong;
  localparam int N = 8;
  localparam int DW = 12;
  localparam int W = N * DW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic lq[$];

  transpose_pingpong_if #(.N(N), .DATA_W(DW)) bus ();
  transpose_pingpong #(.N(N), .DATA_W(DW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_row(input int blk, input int r);
    logic [W-1:0] row;
    for (int c = 0; c < N; c++) row[c*DW +: DW] = DW'(blk * 37 + r * 16 + c);
    return row;
  endfunction

  // element (r,c) of block blk is blk*37 + r*16 + c; beat c of a transposed block holds column c
  task automatic push_block(input int blk, input logic byp);
    logic [W-1:0] beat;
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j < N; j++) beat[j*DW +: DW] = byp ? DW'(blk * 37 + c * 16 + j) : DW'(blk * 37 + j * 16 + c);
      exp_q.push_back(beat);
      lq.push_back(c == N - 1);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic b, input logic r,
                      output logic ordy, output logic ov, output logic [W-1:0] od, output logic ol);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_data = d;
    bus.i_ready = r;
`ifdef TRANSPOSE_BYPASS_EN
    bus.i_bypass = b;
`endif
    #1;
    ordy = bus.o_ready;
    ov = bus.o_valid;
    od = bus.o_data;
    ol = bus.o_last;
  endtask

  task automatic test_reset();
    logic ordy, ov, ol;
    logic [W-1:0] od;
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, ordy, ov, od, ol);
    step(1'b0, '0, 1'b0, 1'b0, ordy, ov, od, ol);
    total += 4;
    if (ordy !== 1'b1) begin bad++; $display("FAIL reset_o_ready got %b want 1", ordy); end
    if (ov !== 1'b0) begin bad++; $display("FAIL reset_o_valid got %b want 0", ov); end
    if (ol !== 1'b0) begin bad++; $display("FAIL reset_o_last got %b want 0", ol); end
    if (od !== '0) begin bad++; $display("FAIL reset_o_data got %h want 0", od); end
    rst = 1'b0;
    exp_q.delete();
    lq.delete();
    step(1'b0, '0, 1'b0, 1'b0, ordy, ov, od, ol);
    total++;
    if (ordy !== 1'b1 || ov !== 1'b0) begin bad++; $display("FAIL post_reset_idle got rdy=%b vld=%b want 1/0", ordy, ov); end
  endtask

  task automatic test_basic();
    logic ordy, ov, ol, el, v;
    logic [W-1:0] od, e;
    int row = 0, nb = 0, k_last = -1, first_v = -1;
    for (int cyc = 0; cyc < 40 && (row < N || exp_q.size() > 0); cyc++) begin
      v = row < N;
      step(v, mk_row(0, row), 1'b0, 1'b1, ordy, ov, od, ol);
      if (ov && first_v < 0) first_v = cyc;
      if (ov) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL basic_extra_beat got %h", od); end
        else begin
          e = exp_q.pop_front(); el = lq.pop_front();
          if (od !== e || ol !== el) begin bad++; $display("FAIL basic_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        end
        nb++;
      end
      if (v && ordy) begin
        if (row == N - 1) begin k_last = cyc; push_block(0, 1'b0); end
        row++;
      end
    end
    total += 2;
    if (first_v !== k_last + 1) begin bad++; $display("FAIL basic_latency got first_valid=%0d want %0d", first_v, k_last + 1); end
    if (nb !== N) begin bad++; $display("FAIL basic_beat_count got %0d want %0d", nb, N); end
  endtask

  task automatic test_streaming();
    logic ordy, ov, ol, el, v;
    logic [W-1:0] od, e;
    int sent = 0, nb = 0, first_c = -1, last_c = -1, rdy_bad = 0;
    for (int cyc = 0; cyc < 100 && (sent < 4 * N || exp_q.size() > 0); cyc++) begin
      v = sent < 4 * N;
      step(v, mk_row(1 + sent / N, sent % N), 1'b0, 1'b1, ordy, ov, od, ol);
      if (v && ordy !== 1'b1) rdy_bad++;
      if (ov) begin
        total++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra_beat got %h", od); end
        else begin
          e = exp_q.pop_front(); el = lq.pop_front();
          if (od !== e || ol !== el) begin bad++; $display("FAIL stream_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        end
        nb++;
      end
      if (v && ordy) begin
        if (sent % N == N - 1) push_block(1 + sent / N, 1'b0);
        sent++;
      end
    end
    total += 3;
    if (rdy_bad !== 0) begin bad++; $display("FAIL stream_o_ready_drops got %0d want 0", rdy_bad); end
    if (nb !== 4 * N) begin bad++; $display("FAIL stream_beat_count got %0d want %0d", nb, 4 * N); end
    if (last_c - first_c + 1 !== 4 * N) begin bad++; $display("FAIL stream_contiguous got span=%0d want %0d", last_c - first_c + 1, 4 * N); end
  endtask

  task automatic test_backpressure();
    logic ordy, ov, ol, el;
    logic [W-1:0] od, e, cap;
    int sent = 0, nb = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1'b1, mk_row(30 + sent / N, sent % N), 1'b0, 1'b0, ordy, ov, od, ol);
      if (cyc == 16) cap = od;
      if (cyc >= 16) begin
        total += 2;
        if (ordy !== 1'b0) begin bad++; $display("FAIL bp_o_ready cyc%0d got %b want 0", cyc, ordy); end
        if (ov !== 1'b1 || od !== cap) begin bad++; $display("FAIL bp_hold cyc%0d got vld=%b %h want 1 %h", cyc, ov, od, cap); end
      end
      if (ordy) begin
        if (sent % N == N - 1 && sent < 2 * N) push_block(30 + sent / N, 1'b0);
        sent++;
      end
    end
    total++;
    if (sent !== 2 * N) begin bad++; $display("FAIL bp_rows_taken got %0d want %0d", sent, 2 * N); end
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      step(1'b0, '0, 1'b0, 1'b1, ordy, ov, od, ol);
      if (ov) begin
        total++;
        e = exp_q.pop_front(); el = lq.pop_front();
        if (od !== e || ol !== el) begin bad++; $display("FAIL bp_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        nb++;
      end
    end
    total++;
    if (nb !== 2 * N) begin bad++; $display("FAIL bp_drain_count got %0d want %0d", nb, 2 * N); end
  endtask

  task automatic test_random();
    logic ordy, ov, ol, el, v, r;
    logic [W-1:0] od, e;
    int sent = 0, nb = 0, nlast = 0;
    for (int cyc = 0; cyc < 4000 && (sent < 20 * N || exp_q.size() > 0); cyc++) begin
      v = sent < 20 * N && $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      step(v, mk_row(100 + sent / N, sent % N), 1'b0, r, ordy, ov, od, ol);
      if (ov && r) begin
        total++;
        if (ol) nlast++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra_beat got %h", od); end
        else begin
          e = exp_q.pop_front(); el = lq.pop_front();
          if (od !== e || ol !== el) begin bad++; $display("FAIL rand_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        end
        nb++;
      end
      if (v && ordy) begin
        if (sent % N == N - 1) push_block(100 + sent / N, 1'b0);
        sent++;
      end
    end
    total += 2;
    if (nlast !== 20) begin bad++; $display("FAIL rand_last_count got %0d want 20", nlast); end
    if (nb !== 20 * N) begin bad++; $display("FAIL rand_beat_count got %0d want %0d", nb, 20 * N); end
  endtask

  task automatic test_reset_mid();
    logic ordy, ov, ol, el, v;
    logic [W-1:0] od, e;
    int sent = 0, nb = 0;
    for (int cyc = 0; cyc < N + 4; cyc++) begin
      step(1'b1, mk_row(60 + sent / N, sent % N), 1'b0, cyc >= N && cyc < N + 3, ordy, ov, od, ol);
      if (ov && cyc >= N && cyc < N + 3) begin
        total++;
        e = exp_q.pop_front(); el = lq.pop_front();
        if (od !== e || ol !== el) begin bad++; $display("FAIL rmid_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        nb++;
      end
      if (ordy) begin
        if (sent == N - 1) push_block(60, 1'b0);
        sent++;
      end
    end
    total++;
    if (sent !== N + 4 || nb !== 3) begin bad++; $display("FAIL rmid_setup got rows=%0d beats=%0d want %0d/3", sent, nb, N + 4); end
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, ordy, ov, od, ol);
    rst = 1'b0;
    exp_q.delete();
    lq.delete();
    step(1'b0, '0, 1'b0, 1'b0, ordy, ov, od, ol);
    total++;
    if (ordy !== 1'b1 || ov !== 1'b0 || od !== '0) begin bad++; $display("FAIL rmid_after_reset got rdy=%b vld=%b data=%h want 1/0/0", ordy, ov, od); end
    sent = 0;
    nb = 0;
    for (int cyc = 0; cyc < 40 && (sent < N || exp_q.size() > 0); cyc++) begin
      v = sent < N;
      step(v, mk_row(62, sent), 1'b0, 1'b1, ordy, ov, od, ol);
      if (ov) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rmid_extra_beat got %h", od); end
        else begin
          e = exp_q.pop_front(); el = lq.pop_front();
          if (od !== e || ol !== el) begin bad++; $display("FAIL rmid_fresh_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        end
        nb++;
      end
      if (v && ordy) begin
        if (sent == N - 1) push_block(62, 1'b0);
        sent++;
      end
    end
    total++;
    if (nb !== N) begin bad++; $display("FAIL rmid_fresh_count got %0d want %0d", nb, N); end
  endtask

`ifdef TRANSPOSE_BYPASS_EN
  task automatic test_bypass();
    logic ordy, ov, ol, el, v, mode;
    logic [W-1:0] od, e;
    int sent = 0, nb = 0;
    for (int cyc = 0; cyc < 60 && (sent < 2 * N || exp_q.size() > 0); cyc++) begin
      v = sent < 2 * N;
      mode = sent < N;
      step(v, mk_row(50 + sent / N, sent % N), (sent % N == 0) ? mode : !mode, 1'b1, ordy, ov, od, ol);
      if (ov) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL byp_extra_beat got %h", od); end
        else begin
          e = exp_q.pop_front(); el = lq.pop_front();
          if (od !== e || ol !== el) begin bad++; $display("FAIL byp_beat%0d got %h last=%b want %h last=%b", nb, od, ol, e, el); end
        end
        nb++;
      end
      if (v && ordy) begin
        if (sent % N == N - 1) push_block(50 + sent / N, mode);
        sent++;
      end
    end
    total++;
    if (nb !== 2 * N) begin bad++; $display("FAIL byp_beat_count got %0d want %0d", nb, 2 * N); end
  endtask
`endif

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_ready = 1'b0;
`ifdef TRANSPOSE_BYPASS_EN
    bus.i_bypass = 1'b0;
`endif
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef TRANSPOSE_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
